hdmi_tx_pll_supervisor: RTL

Lock supervisor and clock-enable sequencer for the HDMI TX PLL, running in the `refclk` domain. It holds the PLL in reset for a fixed time and waits for a stable lock. It then releases per-output-clock enables in a staggered order. It also handles lock loss and runtime video-mode changes (e.g. 148.5 / 74.25 / 27 MHz pixel clocks), re-running the full bring-up sequence each time. It replaces direct use of the raw PLL `locked` signal by downstream video logic.

---
 rtl/hdmi_tx_pll_supervisor.sv | 103 ++++++++++
 1 files changed

// File: rtl/hdmi_tx_pll_supervisor.sv
// hdmi_tx_pll_supervisor: PLL reset/lock supervisor with staggered clock-enable release and runtime mode changes.
module hdmi_tx_pll_supervisor #(
  parameter int NUM_CLKS = 1,
  parameter int NUM_MODES = 4,
  parameter int MODE_W = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1,
  parameter int DEFAULT_MODE = 0,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int RELEASE_GAP = 4
) (
  input  logic refclk,
  input  logic rst_n,
  input  logic pll_locked,
  output logic pll_rst,
  output logic [MODE_W-1:0] pll_mode,
  input  logic [MODE_W-1:0] mode_req,
  input  logic mode_req_valid,
  output logic mode_req_ready,
  output logic [NUM_CLKS-1:0] clk_en,
  output logic ready,
  output logic timeout_err,
  output logic [7:0] lock_lost_cnt
);
  localparam int M1 = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int M2 = (LOCK_TIMEOUT_CYCLES > RELEASE_GAP) ? LOCK_TIMEOUT_CYCLES : RELEASE_GAP;
  localparam int CNT_W = $clog2(((M1 > M2) ? M1 : M2) + 1);
  localparam logic [MODE_W-1:0] MODE_MAX = MODE_W'(NUM_MODES - 1);
  typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, STABLE, RELEASE, RUN} state_t;
  state_t state;
  logic [1:0] sync;
  logic [CNT_W-1:0] cnt;
  logic lock_s, lose, take;
  logic [MODE_W-1:0] mode_clamped;
  assign lock_s = sync[1];
  assign mode_req_ready = (state == RUN) && lock_s;
  assign lose = !lock_s && (state == RELEASE || state == RUN);
  assign take = mode_req_valid && mode_req_ready;
  assign mode_clamped = (32'(mode_req) >= NUM_MODES) ? MODE_MAX : mode_req;
  // Entry into STABLE already consumes one locked cycle, hence the -2 compare.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      state <= PLL_RST;
      cnt <= '0;
      pll_rst <= 1'b1;
      pll_mode <= MODE_W'(DEFAULT_MODE);
      clk_en <= '0;
      ready <= 1'b0;
      timeout_err <= 1'b0;
      lock_lost_cnt <= '0;
    end else begin
      sync <= {sync[0], pll_locked};
      cnt <= cnt + CNT_W'(1);
      if (lose || take) begin
        state <= PLL_RST;
        cnt <= '0;
        pll_rst <= 1'b1;
        clk_en <= '0;
        ready <= 1'b0;
        if (take) pll_mode <= mode_clamped;
        if (lose && lock_lost_cnt != 8'hff) lock_lost_cnt <= lock_lost_cnt + 8'd1;
      end else begin
        case (state)
          PLL_RST: if (cnt == CNT_W'(PLL_RST_CYCLES - 1)) begin
            state <= WAIT_LOCK;
            pll_rst <= 1'b0;
            cnt <= '0;
          end
          WAIT_LOCK: if (lock_s) begin
            cnt <= '0;
            if (LOCK_STABLE_CYCLES == 1) begin
              state <= RELEASE;
              clk_en <= NUM_CLKS'(1);
            end else state <= STABLE;
          end else if (cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            state <= PLL_RST;
            pll_rst <= 1'b1;
            cnt <= '0;
          end
          STABLE: if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt <= '0;
          end else if (cnt == CNT_W'(LOCK_STABLE_CYCLES - 2)) begin
            state <= RELEASE;
            clk_en <= NUM_CLKS'(1);
            cnt <= '0;
          end
          RELEASE: if (cnt == CNT_W'(RELEASE_GAP - 1)) begin
            cnt <= '0;
            if (clk_en[NUM_CLKS-1]) begin
              state <= RUN;
              ready <= 1'b1;
            end else clk_en <= (clk_en << 1) | NUM_CLKS'(1);
          end
          RUN: ;
          default: state <= PLL_RST;
        endcase
      end
    end
  end
endmodule
